// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receives an MSB-first bit stream, hunts for a W-bit sync pattern and then
//   deserializes FRAME_LEN data words (FRAME_LEN = 0 keeps the receiver locked
//   indefinitely). Each completed word is offered on a one-entry holding
//   register with a DV/RD handshake; a word that arrives while the previous one
//   is still unread (and not being read on that edge) is dropped and latches
//   the sticky OVR flag.
//
// Ports
//   C     in   1  clock, rising edge
//   RN    in   1  asynchronous active-low reset
//   SI    in   1  serial data, MSB first
//   EN    in   1  bit-valid strobe; SI is sampled only when EN=1
//   RD    in   1  consumer acknowledge for DOUT
//   DOUT  out  W  last completed data word (held after DV clears)
//   DV    out  1  DOUT holds an unread word
//   LOCK  out  1  sync found, collecting frame data
//   OVR   out  1  sticky overrun, cleared only by reset
module serial_frame_rx #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   SYNC      = 8'hA5,
  parameter int             FRAME_LEN = 2
) (
  input  logic         C,
  input  logic         RN,
  input  logic         SI,
  input  logic         EN,
  input  logic         RD,
  output logic [W-1:0] DOUT,
  output logic         DV,
  output logic         LOCK,
  output logic         OVR
);

  localparam int BCW = (W > 2) ? $clog2(W) : 1;
  localparam int FCW = $clog2(W + 1);
  localparam int WCW = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
  localparam logic [FCW-1:0] FILL_FULL = FCW'(W);
  localparam logic [WCW-1:0] WORD_LAST = (FRAME_LEN == 0) ? '0 : WCW'(FRAME_LEN - 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t         state;
  // Only the W-1 most recent bits need storing: the incoming SI supplies the
  // W-th bit of both the sync window and the data word.
  logic [W-2:0]   win;
  logic [W-2:0]   shreg;
  logic [FCW-1:0] fill;
  logic [BCW-1:0] bit_cnt;
  logic [WCW-1:0] word_cnt;

  logic [W-1:0]   win_nxt;
  logic [W-1:0]   word_nxt;
  logic [FCW-1:0] fill_nxt;
  logic           match;
  logic           word_done;
  logic           frame_end;

  always_comb begin
    win_nxt   = {win, SI};
    word_nxt  = {shreg, SI};
    fill_nxt  = (fill == FILL_FULL) ? fill : fill + 1'b1;
    // The fill requirement keeps the reset-zero window from matching SYNC=0.
    match     = (win_nxt == SYNC) && (fill_nxt == FILL_FULL);
    word_done = (state == COLLECT) && (bit_cnt == BIT_LAST);
    frame_end = (FRAME_LEN != 0) && (word_cnt == WORD_LAST);
  end

  // Data shift register carries no reset: every word is fully refilled
  // before it is ever presented.
  always_ff @(posedge C) begin
    if (EN && state == COLLECT) begin
      shreg <= word_nxt[W-2:0];
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state    <= HUNT;
      win      <= '0;
      fill     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      DOUT     <= '0;
      DV       <= 1'b0;
      LOCK     <= 1'b0;
      OVR      <= 1'b0;
    end else begin
      // Read handshake runs regardless of EN; a word-complete edge below
      // overrides it.
      if (RD && DV) begin
        DV <= 1'b0;
      end

      if (EN) begin
        case (state)
          HUNT: begin
            win  <= win_nxt[W-2:0];
            fill <= fill_nxt;
            if (match) begin
              state    <= COLLECT;
              LOCK     <= 1'b1;
              bit_cnt  <= '0;
              word_cnt <= '0;
            end
          end

          COLLECT: begin
            if (word_done) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + 1'b1;
              // Refill when empty or when the held word is read on this edge;
              // otherwise the new word is lost.
              if (!DV || RD) begin
                DOUT <= word_nxt;
                DV   <= 1'b1;
              end else begin
                OVR  <= 1'b1;
              end
              if (frame_end) begin
                state <= HUNT;
                LOCK  <= 1'b0;
                win   <= '0;
                fill  <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam logic [7:0] SYNC_B = 8'hA5;

  logic       C  = 1'b0;
  logic       RN = 1'b0;
  logic       SI = 1'b0;
  logic       EN = 1'b0;
  logic       RD = 1'b0;
  logic [7:0] dout [2];
  logic       dv   [2];
  logic       lock [2];
  logic       ovr  [2];

  int checks   = 0;
  int failures = 0;

  always #5 C = ~C;

  serial_frame_rx #(.W(8), .SYNC(8'hA5), .FRAME_LEN(2)) u0 (
    .C(C), .RN(RN), .SI(SI), .EN(EN), .RD(RD),
    .DOUT(dout[0]), .DV(dv[0]), .LOCK(lock[0]), .OVR(ovr[0])
  );

  serial_frame_rx #(.W(8), .SYNC(8'hA5), .FRAME_LEN(0)) u1 (
    .C(C), .RN(RN), .SI(SI), .EN(EN), .RD(RD),
    .DOUT(dout[1]), .DV(dv[1]), .LOCK(lock[1]), .OVR(ovr[1])
  );

  // ---------------- reference model (one per instance) ----------------
  int         flen   [2] = '{2, 0};
  int         m_cnt  [2];   // bits seen since the hunt began
  int         m_hist [2];   // last 8 bits as a number
  int         m_word [2];
  int         m_nb   [2];
  int         m_nw   [2];
  bit         m_lock [2];
  bit         m_dv   [2];
  bit         m_ovr  [2];
  logic [7:0] m_dout [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_hist[k] = 0; m_word[k] = 0; m_nb[k] = 0; m_nw[k] = 0;
      m_lock[k] = 0; m_dv[k] = 0; m_ovr[k] = 0; m_dout[k] = 8'h00;
    end
  endtask

  task automatic model_edge(input bit si, input bit en, input bit rd);
    for (int k = 0; k < 2; k++) begin
      bit done;
      done = 0;
      if (en) begin
        if (!m_lock[k]) begin
          m_hist[k] = ((m_hist[k] << 1) | int'(si)) & 255;
          m_cnt[k]++;
          if (m_cnt[k] >= 8 && m_hist[k] == int'(SYNC_B)) begin
            m_lock[k] = 1; m_nb[k] = 0; m_nw[k] = 0;
          end
        end else begin
          m_word[k] = ((m_word[k] << 1) | int'(si)) & 255;
          m_nb[k]++;
          if (m_nb[k] == 8) begin
            done = 1; m_nb[k] = 0; m_nw[k]++;
          end
        end
      end
      if (done) begin
        if (!m_dv[k] || rd) begin
          m_dout[k] = m_word[k][7:0];
          m_dv[k]   = 1;
        end else begin
          m_ovr[k] = 1;
        end
        if (flen[k] != 0 && m_nw[k] == flen[k]) begin
          m_lock[k] = 0; m_cnt[k] = 0; m_hist[k] = 0;
        end
      end else if (rd && m_dv[k]) begin
        m_dv[k] = 0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs(input int k);
    return {dout[k], dv[k], lock[k], ovr[k]};
  endfunction

  function automatic logic [10:0] m_outs(input int k);
    return {m_dout[k], m_dv[k], m_lock[k], m_ovr[k]};
  endfunction

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic do_cycle(input bit si, input bit en, input bit rd);
    SI = si; EN = en; RD = rd;
    @(posedge C);
    if (RN) model_edge(si, en, rd);
    else    model_reset();
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("model_u%0d", k), outs(k), m_outs(k));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rd_last);
    for (int i = 0; i < 8; i++) do_cycle(b[7-i], 1'b1, rd_last && (i == 7));
  endtask

  task automatic do_reset();
    RN = 1'b0;
    model_reset();
    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    RN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    bit         rd_last;
    bit         rd_after;
    logic [7:0] e_dout;
    bit         e_dv;
    bit         e_lock;
    bit         e_ovr;
    bit         e_lock_mid;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] w;
    logic [7:0] nb;
    bit         q [$];
    int         cyc;

    tbl[0]  = '{8'hFF, 0, 0, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{8'hA5, 0, 0, 8'h00, 0, 1, 0, 0};
    tbl[2]  = '{8'h12, 0, 1, 8'h12, 1, 1, 0, 1};
    tbl[3]  = '{8'h34, 0, 1, 8'h34, 1, 0, 0, 1};
    tbl[4]  = '{8'hA5, 0, 0, 8'h34, 0, 1, 0, 0};
    tbl[5]  = '{8'h3C, 0, 0, 8'h3C, 1, 1, 0, 1};
    tbl[6]  = '{8'hC3, 1, 1, 8'hC3, 1, 0, 0, 1};
    tbl[7]  = '{8'hA5, 0, 0, 8'hC3, 0, 1, 0, 0};
    tbl[8]  = '{8'h3C, 0, 0, 8'h3C, 1, 1, 0, 1};
    tbl[9]  = '{8'hC3, 0, 1, 8'h3C, 1, 0, 1, 1};
    tbl[10] = '{8'hFF, 0, 0, 8'h3C, 0, 0, 1, 0};

    // ---- reset state ----
    model_reset();
    #1;
    chk("reset_u0", outs(0), 11'h0);
    chk("reset_u1", outs(1), 11'h0);
    do_cycle(1'b1, 1'b1, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b0);
    RN = 1'b1;

    // ---- reset mid-COLLECT, then a clean frame ----
    send_byte(8'hA5, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("pre_reset_lock", lock[0], 1'b1);
    #2;
    RN = 1'b0;
    #1;
    model_reset();
    chk("async_reset_u0", outs(0), 11'h0);
    chk("async_reset_u1", outs(1), 11'h0);
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("held_reset_u0", outs(0), 11'h0);
    do_cycle(1'b0, 1'b1, 1'b1);
    chk("held_reset_u0", outs(0), 11'h0);
    RN = 1'b1;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      do_cycle(w[7-i], 1'b1, 1'b0);
      chk($sformatf("sync_lock_bit%0d", i + 1), lock[0], i == 7);
    end
    w = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      do_cycle(w[7-i], 1'b1, 1'b0);
      chk($sformatf("w0_dv_bit%0d", i + 9), dv[0], i == 7);
    end
    chk("w0_dout", dout[0], 8'h3C);
    do_cycle(1'b0, 1'b0, 1'b1);
    chk("rd_clears_dv", dv[0], 1'b0);
    chk("dout_retained", dout[0], 8'h3C);
    send_byte(8'hC3, 1'b0);
    chk("w1_dout", dout[0], 8'hC3);
    chk("w1_dv", dv[0], 1'b1);
    chk("frame_end_lock", lock[0], 1'b0);

    // ---- table-driven byte sequences ----
    do_reset();
    for (int r = 0; r < 11; r++) begin
      for (int i = 0; i < 8; i++) begin
        do_cycle(tbl[r].b[7-i], 1'b1, tbl[r].rd_last && (i == 7));
        if (i < 7) chk($sformatf("tbl%0d_lock_mid", r), lock[0], tbl[r].e_lock_mid);
      end
      chk($sformatf("tbl%0d_dout", r), dout[0], tbl[r].e_dout);
      chk($sformatf("tbl%0d_dv", r),   dv[0],   tbl[r].e_dv);
      chk($sformatf("tbl%0d_lock", r), lock[0], tbl[r].e_lock);
      chk($sformatf("tbl%0d_ovr", r),  ovr[0],  tbl[r].e_ovr);
      if (tbl[r].rd_after) do_cycle(1'b0, 1'b0, 1'b1);
    end

    // ---- EN gating inside a word ----
    do_reset();
    send_byte(8'hA5, 1'b0);
    w = 8'h5A;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      do_cycle(w[7-i], 1'b1, 1'b0); cyc++;
      chk("gate_dv", dv[0], cyc == 13);
    end
    for (int j = 0; j < 5; j++) begin
      do_cycle(j[0], 1'b0, 1'b0); cyc++;
      chk("gate_dv", dv[0], cyc == 13);
    end
    for (int i = 4; i < 8; i++) begin
      do_cycle(w[7-i], 1'b1, 1'b0); cyc++;
      chk("gate_dv", dv[0], cyc == 13);
    end
    chk("gate_dout", dout[0], 8'h5A);

    // ---- FRAME_LEN=0 instance stays locked ----
    do_reset();
    send_byte(8'hA5, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      send_byte(8'(n), 1'b0);
      chk($sformatf("free_dout%0d", n), dout[1], 8'(n));
      chk($sformatf("free_dv%0d", n), dv[1], 1'b1);
      chk($sformatf("free_lock%0d", n), lock[1], 1'b1);
      do_cycle(1'b0, 1'b0, 1'b1);
      chk($sformatf("free_rd%0d", n), dv[1], 1'b0);
    end

    // ---- randomized stream against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit en, si, rd;
      if (q.size() < 8) begin
        nb = (($urandom % 3) == 0) ? SYNC_B : 8'($urandom);
        for (int j = 7; j >= 0; j--) q.push_back(nb[j]);
      end
      en = ($urandom % 4) != 0;
      si = en ? q.pop_front() : 1'($urandom);
      rd = ($urandom % 3) == 0;
      if (($urandom % 800) == 0) do_reset();
      else do_cycle(si, en, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
